// File: rtl/shift_add_multiplier_n.sv
// Sequential shift-add multiplier, signed or unsigned; done_o pulses 2*WIDTH+1 cycles after start.
// No backpressure: inputs other than start_i are ignored while busy, result held in HALT until start_i drops.
module shift_add_multiplier_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 load_b_i,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [WIDTH-1:0]     a_o,
    output logic [WIDTH-1:0]     b_o,
    output logic                 x_o,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             x_q, x_d;
    logic             sgn_q, sgn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic             last_iter;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Sign-extend in signed mode, zero-extend otherwise; the top bit of the
    // WIDTH+1 result is then either the sign or the carry out.
    always_comb begin
        a_ext = {sgn_q & a_q[WIDTH-1], a_q};
        m_ext = {sgn_q & m_q[WIDTH-1], m_q};
        if (sgn_q && last_iter) begin
            sum = a_ext - m_ext;
        end else begin
            sum = a_ext + m_ext;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        x_d     = x_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_b_i) begin
                    b_d = b_i;
                    a_d = '0;
                    x_d = 1'b0;
                end else if (start_i) begin
                    // B is kept so a chained multiply uses the previous low half
                    a_d     = '0;
                    x_d     = 1'b0;
                    m_d     = a_i;
                    sgn_d   = signed_i;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (b_q[0]) begin
                    {x_d, a_d} = sum;
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                b_d = {a_q[0], b_q[WIDTH-1:1]};
                a_d = {x_q, a_q[WIDTH-1:1]};
                x_d = sgn_q & x_q;
                if (last_iter) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_ADD;
                end
            end
            default: begin
                if (load_b_i) begin
                    b_d = b_i;
                    a_d = '0;
                    x_d = 1'b0;
                end
                if (!start_i) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            x_q     <= 1'b0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            x_q     <= x_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign x_o       = x_q;
    assign product_o = {a_q, b_q};
    assign busy_o    = (state_q == S_ADD) || (state_q == S_SHIFT);
    assign done_o    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier_n.sv
// Directed bench for shift_add_multiplier_n at WIDTH=8 (table plus corner sequences) and WIDTH=16.
module tb_shift_add_multiplier_n;

    typedef struct {
        logic        sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        logic        x;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_b, start, sgn;
    logic [7:0]  a_in, b_in;
    logic [7:0]  a_out, b_out;
    logic        x_out, busy, done;
    logic [15:0] prod;

    logic        load16, start16, sgn16;
    logic [15:0] a16_in, b16_in, a16_out, b16_out;
    logic        x16_out, busy16, done16;
    logic [31:0] prod16;

    int n_total = 0;
    int n_pass  = 0;
    int done_cyc;
    int busy_bad;

    vec_t vecs[10];

    always #5 clk = ~clk;

    shift_add_multiplier_n #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(reset), .load_b_i(load_b), .start_i(start),
        .signed_i(sgn), .a_i(a_in), .b_i(b_in), .a_o(a_out), .b_o(b_out),
        .x_o(x_out), .product_o(prod), .busy_o(busy), .done_o(done)
    );

    shift_add_multiplier_n #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(reset), .load_b_i(load16), .start_i(start16),
        .signed_i(sgn16), .a_i(a16_in), .b_i(b16_in), .a_o(a16_out), .b_o(b16_out),
        .x_o(x16_out), .product_o(prod16), .busy_o(busy16), .done_o(done16)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called at a negedge; leaves the bench at the next negedge with B loaded.
    task automatic load8(input logic [7:0] b);
        load_b = 1'b1;
        b_in   = b;
        @(negedge clk);
        load_b = 1'b0;
        chk("b_after_load", {24'd0, b_out}, {24'd0, b});
    endtask

    // Raises start and waits for done; cycle n is observed at the n-th negedge.
    task automatic run8(input logic [7:0] a, input logic s);
        start    = 1'b1;
        a_in     = a;
        sgn      = s;
        done_cyc = 0;
        busy_bad = 0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (busy !== (c <= 16)) busy_bad++;
            if (done === 1'b1) done_cyc = c;
        end
        chk("done_cycle", done_cyc, 17);
        chk("busy_window", busy_bad, 0);
    endtask

    task automatic drop_start();
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
        vecs[1] = '{1'b1, 8'h80, 8'h7F, 16'hC080, 1'b1};
        vecs[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0};
        vecs[3] = '{1'b1, 8'h80, 8'h80, 16'h4000, 1'b0};
        vecs[4] = '{1'b0, 8'h05, 8'h03, 16'h000F, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 8'h55, 16'h0000, 1'b0};
        vecs[6] = '{1'b1, 8'h03, 8'hFB, 16'hFFF1, 1'b1};
        vecs[7] = '{1'b1, 8'hFB, 8'h03, 16'hFFF1, 1'b1};
        vecs[8] = '{1'b0, 8'h80, 8'h02, 16'h0100, 1'b0};
        vecs[9] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 1'b0};

        reset = 1'b1; load_b = 1'b0; start = 1'b0; sgn = 1'b0; a_in = '0; b_in = '0;
        load16 = 1'b0; start16 = 1'b0; sgn16 = 1'b0; a16_in = '0; b16_in = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_product", {16'd0, prod}, 32'd0);
        chk("reset_x", {31'd0, x_out}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            load8(vecs[i].b);
            run8(vecs[i].a, vecs[i].sgn);
            chk($sformatf("vec%0d_product", i), {16'd0, prod}, {16'd0, vecs[i].prod});
            chk($sformatf("vec%0d_x", i), {31'd0, x_out}, {31'd0, vecs[i].x});
            drop_start();
        end

        // Chained multiply reuses the previous low half as B.
        load8(8'h03);
        run8(8'h05, 1'b0);
        chk("chain_first", {16'd0, prod}, 32'h000F);
        drop_start();
        run8(8'h02, 1'b0);
        chk("chain_second", {16'd0, prod}, 32'h001E);
        drop_start();

        // Reset during an operation aborts it without a done pulse.
        load8(8'h09);
        start = 1'b1; a_in = 8'h0B; sgn = 1'b0;
        for (int c = 1; c <= 5; c++) @(negedge clk);
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("abort_product", {16'd0, prod}, 32'd0);
        chk("abort_x", {31'd0, x_out}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        busy_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) busy_bad++;
        end
        chk("no_done_after_abort", busy_bad, 0);

        // Load and operand changes while busy are ignored.
        load8(8'h04);
        start = 1'b1; a_in = 8'h03; sgn = 1'b0;
        @(negedge clk);
        load_b = 1'b1; b_in = 8'h02; a_in = 8'h77; sgn = 1'b1;
        for (int c = 0; c < 4; c++) @(negedge clk);
        load_b = 1'b0;
        done_cyc = 0;
        for (int c = 6; c <= 40 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_cyc = c;
        end
        chk("busy_ignore_done_cycle", done_cyc, 17);
        chk("busy_ignore_product", {16'd0, prod}, 32'h000C);
        drop_start();

        // Holding start after done neither restarts nor re-pulses done.
        load8(8'h02);
        run8(8'h03, 1'b0);
        chk("hold_first", {16'd0, prod}, 32'h0006);
        busy_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) busy_bad++;
        end
        chk("hold_quiet", busy_bad, 0);
        chk("hold_product", {16'd0, prod}, 32'h0006);
        drop_start();
        run8(8'h04, 1'b0);
        chk("hold_rerun", {16'd0, prod}, 32'h0018);
        drop_start();

        // load_b wins over start in the same cycle; start is taken next cycle.
        load_b = 1'b1; b_in = 8'h06; start = 1'b1; a_in = 8'h07; sgn = 1'b0;
        @(negedge clk);
        load_b = 1'b0;
        chk("prio_not_busy", {31'd0, busy}, 32'd0);
        chk("prio_b_loaded", {24'd0, b_out}, 32'h06);
        run8(8'h07, 1'b0);
        chk("prio_product", {16'd0, prod}, 32'h002A);
        drop_start();

        // WIDTH=16 most-negative squared.
        load16 = 1'b1; b16_in = 16'h8000;
        @(negedge clk);
        load16 = 1'b0;
        start16 = 1'b1; a16_in = 16'h8000; sgn16 = 1'b1;
        done_cyc = 0;
        for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (done16 === 1'b1) done_cyc = c;
        end
        chk("w16_done_cycle", done_cyc, 33);
        chk("w16_product", prod16, 32'h40000000);
        chk("w16_x", {31'd0, x16_out}, 32'd0);
        start16 = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
